multi_flow_block_arbiter: RTL and testbench

//  Merges FLUX independent pixel flows into one tagged stream for a shared multi-dataflow accelerator.

---
 rtl/multi_flow_block_arbiter_if.sv | 32 +++
 rtl/multi_flow_block_arbiter.sv | 159 +++++++++++++++
 tb/tb_multi_flow_block_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_flow_block_arbiter_if.sv
// Bundle of per-flow input streams, merged tagged output stream and block status
// shared by the arbiter and whatever drives it.
interface multi_flow_block_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FLUX   = 2,
    parameter int unsigned LEN_W  = 16
);
    localparam int unsigned TAG_W = $clog2(FLUX);

    logic [LEN_W-1:0]         cfg_blk_len;
    logic [FLUX*DATA_W-1:0]   in_din;
    logic [FLUX-1:0]          in_last;
    logic [FLUX-1:0]          in_write;
    logic [FLUX-1:0]          in_full;
    logic [FLUX-1:0]          in_ovf;
    logic [TAG_W+DATA_W-1:0]  out_din;
    logic                     out_last;
    logic                     out_write;
    logic                     out_full;
    logic [TAG_W-1:0]         cur_flow;
    logic                     blk_done;

    modport master (
        output cfg_blk_len, in_din, in_last, in_write, out_full,
        input  in_full, in_ovf, out_din, out_last, out_write, cur_flow, blk_done
    );

    modport slave (
        input  cfg_blk_len, in_din, in_last, in_write, out_full,
        output in_full, in_ovf, out_din, out_last, out_write, cur_flow, blk_done
    );
endinterface

// File: rtl/multi_flow_block_arbiter.sv
// Merges FLUX buffered pixel flows into one {tag, data} stream, granting
// round-robin one block at a time with a run-time block length.
module multi_flow_block_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FLUX   = 2,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = 16
) (
    input logic clk,
    input logic rst,
    multi_flow_block_arbiter_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(FLUX);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    logic [DATA_W:0]    mem    [FLUX][DEPTH];
    logic [PTR_W-1:0]   wr_ptr [FLUX];
    logic [PTR_W-1:0]   rd_ptr [FLUX];
    logic [CNT_W-1:0]   fcnt   [FLUX];
    logic [CNT_W-1:0]   fcnt_nx[FLUX];
    logic [FLUX-1:0]    full_q;
    logic [FLUX-1:0]    ovf_q;
    logic [FLUX-1:0]    push;
    logic [FLUX-1:0]    pop;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   cur_q, cur_d;
    logic [TAG_W-1:0]   last_grant_q, last_grant_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               pop_c;
    logic               done_c;
    logic               hit;
    logic [TAG_W-1:0]   scand;
    int unsigned        sidx;
    logic [DATA_W:0]    rd_elem;

    logic [TAG_W+DATA_W-1:0] out_din_q;
    logic                    out_last_q;
    logic                    out_write_q;
    logic                    blk_done_q;

    assign rd_elem = mem[cur_q][rd_ptr[cur_q]];

    // A write only lands when the registered full flag is clear; a same-edge pop does not help.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            push[i]    = bus.in_write[i] && !full_q[i];
            pop[i]     = pop_c && (cur_q == TAG_W'(i));
            fcnt_nx[i] = fcnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {bus.in_last[i], bus.in_din[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fcnt[i]   <= '0;
            end
            full_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                fcnt[i]   <= fcnt_nx[i];
                full_q[i] <= (fcnt_nx[i] == CNT_W'(DEPTH));
                if (bus.in_write[i] && full_q[i]) ovf_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            last_grant_q <= TAG_W'(FLUX - 1);
            cnt_q        <= '0;
            out_din_q    <= '0;
            out_last_q   <= 1'b0;
            out_write_q  <= 1'b0;
            blk_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            out_write_q  <= pop_c;
            blk_done_q   <= done_c;
            if (pop_c) begin
                out_din_q  <= {cur_q, rd_elem[DATA_W-1:0]};
                out_last_q <= rd_elem[DATA_W];
            end
        end
    end

    // Grant search in IDLE, one pop per cycle in BURST until length or last marker.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pop_c        = 1'b0;
        done_c       = 1'b0;
        hit          = 1'b0;
        scand        = '0;
        sidx         = 0;
        case (state_q)
            IDLE: begin
                for (int unsigned k = 1; k <= FLUX; k++) begin
                    sidx = 32'(last_grant_q) + k;
                    if (sidx >= FLUX) sidx = sidx - FLUX;
                    if (!hit && (fcnt[TAG_W'(sidx)] != '0)) begin
                        hit   = 1'b1;
                        scand = TAG_W'(sidx);
                    end
                end
                if (hit) begin
                    cur_d        = scand;
                    last_grant_d = scand;
                    cnt_d        = (bus.cfg_blk_len == '0) ? LEN_W'(1) : bus.cfg_blk_len;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if ((fcnt[cur_q] != '0) && !bus.out_full) begin
                    pop_c = 1'b1;
                    cnt_d = cnt_q - LEN_W'(1);
                    if ((cnt_q == LEN_W'(1)) || rd_elem[DATA_W]) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_full   = full_q;
    assign bus.in_ovf    = ovf_q;
    assign bus.out_din   = out_din_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_write = out_write_q;
    assign bus.cur_flow  = cur_q;
    assign bus.blk_done  = blk_done_q;
endmodule

// File: tb/tb_multi_flow_block_arbiter.sv
// Directed and randomized bench for multi_flow_block_arbiter, checked every cycle
// against a queue-based model of the flows, the grant rotation and the block rules.
module tb_multi_flow_block_arbiter;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLUX   = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned TAG_W  = $clog2(FLUX);

    typedef logic [DATA_W:0] elem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_flow_block_arbiter_if #(.DATA_W(DATA_W), .FLUX(FLUX), .LEN_W(LEN_W)) bus ();

    multi_flow_block_arbiter #(.DATA_W(DATA_W), .FLUX(FLUX), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // model state
    elem_t           mq [FLUX][$];
    int              mgrant = -1;
    int              mlast  = FLUX - 1;
    int              mcur   = 0;
    int              mrem   = 0;
    logic [FLUX-1:0] movf   = '0;
    int              blkpos = 0;
    int              wcount = 0;
    int              words [FLUX];
    int              log_tag[$];
    int              log_len[$];
    int              log_last[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic apply(input logic [FLUX-1:0] w, input logic [FLUX*DATA_W-1:0] d,
                         input logic [FLUX-1:0] l, input logic of);
        bus.in_write = w;
        bus.in_din   = d;
        bus.in_last  = l;
        bus.out_full = of;
    endtask

    task automatic clear_log();
        log_tag.delete();
        log_len.delete();
        log_last.delete();
    endtask

    // Reference: advance the model on every edge, then compare all outputs 1 time unit later.
    always @(posedge clk) begin : monitor
        logic r, of, ew, ed, el;
        logic [FLUX-1:0] w, l, acc;
        logic [FLUX*DATA_W-1:0] d;
        logic [LEN_W-1:0] len;
        logic [TAG_W+DATA_W-1:0] edin;
        elem_t e;
        r = rst; of = bus.out_full; w = bus.in_write; l = bus.in_last;
        d = bus.in_din; len = bus.cfg_blk_len;
        ew = 1'b0; ed = 1'b0; el = 1'b0; edin = '0; acc = '0;
        if (r) begin
            for (int f = 0; f < FLUX; f++) mq[f].delete();
            mgrant = -1; mlast = FLUX - 1; mcur = 0; movf = '0; blkpos = 0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (w[f]) begin
                    if (mq[f].size() < int'(DEPTH)) acc[f] = 1'b1;
                    else movf[f] = 1'b1;
                end
            end
            if (mgrant < 0) begin
                for (int k = 1; k <= FLUX; k++)
                    if (mgrant < 0 && mq[(mlast + k) % FLUX].size() > 0) mgrant = (mlast + k) % FLUX;
                if (mgrant >= 0) begin
                    mlast = mgrant; mcur = mgrant;
                    mrem = (len == '0) ? 1 : int'(len);
                end
            end else if (mq[mgrant].size() > 0 && !of) begin
                e = mq[mgrant].pop_front();
                ew = 1'b1; el = e[DATA_W];
                edin = {TAG_W'(mgrant), e[DATA_W-1:0]};
                mrem--; blkpos++; words[mgrant]++; wcount++;
                if (mrem == 0 || el) begin
                    ed = 1'b1;
                    log_tag.push_back(mgrant); log_len.push_back(blkpos); log_last.push_back(int'(el));
                    blkpos = 0; mgrant = -1;
                end
            end
            for (int f = 0; f < FLUX; f++)
                if (acc[f]) mq[f].push_back({l[f], d[f*DATA_W +: DATA_W]});
        end
        #1;
        check("out_write", 32'(bus.out_write), 32'(ew));
        check("blk_done", 32'(bus.blk_done), 32'(ed));
        check("cur_flow", 32'(bus.cur_flow), 32'(mcur));
        if (ew || r) begin
            check("out_din", 32'(bus.out_din), 32'(edin));
            check("out_last", 32'(bus.out_last), 32'(el));
        end
        for (int f = 0; f < FLUX; f++) begin
            check($sformatf("in_full[%0d]", f), 32'(bus.in_full[f]), 32'(mq[f].size() == int'(DEPTH)));
            check($sformatf("in_ovf[%0d]", f), 32'(bus.in_ovf[f]), 32'(movf[f]));
        end
    end

    initial begin
        int sent [FLUX];
        int cyc, stall_left, wc0, w0;
        logic stalled, stall_checked;
        logic [FLUX-1:0] w, l;
        logic [FLUX*DATA_W-1:0] d;

        words = '{default: 0};
        bus.cfg_blk_len = LEN_W'(23);
        apply('0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: both flows stream 0..528, 23-word blocks alternating
        sent = '{default: 0}; clear_log(); words = '{default: 0}; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            w = '0; d = '0;
            for (int f = 0; f < FLUX; f++)
                if (sent[f] < 529 && !bus.in_full[f]) begin
                    w[f] = 1'b1; d[f*DATA_W +: DATA_W] = DATA_W'(sent[f]); sent[f]++;
                end
            apply(w, d, '0, 1'b0);
        end while ((sent[0] < 529 || sent[1] < 529 || mq[0].size() > 0 || mq[1].size() > 0) && cyc < 4000);
        check("t1_timeout", 32'(cyc < 4000), 32'd1);
        check("t1_words0", 32'(words[0]), 32'd529);
        check("t1_words1", 32'(words[1]), 32'd529);
        check("t1_blocks", 32'(log_tag.size()), 32'd46);
        for (int i = 0; i < log_tag.size(); i++) check("t1_tag", 32'(log_tag[i]), 32'(i % 2));

        // 2: only flow 1, blocks of 4
        @(negedge clk); bus.cfg_blk_len = LEN_W'(4); apply('0, '0, '0, 1'b0);
        sent = '{default: 0}; clear_log(); cyc = 0;
        do begin
            @(negedge clk); cyc++;
            w = '0; d = '0;
            if (sent[1] < 40 && !bus.in_full[1]) begin
                w[1] = 1'b1; d[DATA_W +: DATA_W] = DATA_W'($urandom); sent[1]++;
            end
            apply(w, d, '0, 1'b0);
        end while ((sent[1] < 40 || mq[1].size() > 0) && cyc < 1000);
        check("t2_timeout", 32'(cyc < 1000), 32'd1);
        check("t2_cur_flow", 32'(bus.cur_flow), 32'd1);
        check("t2_blocks", 32'(log_tag.size()), 32'd10);
        for (int i = 0; i < log_tag.size(); i++) check("t2_tag", 32'(log_tag[i]), 32'd1);

        // 3: 5-cycle downstream stall in the middle of a block
        @(negedge clk); bus.cfg_blk_len = LEN_W'(23); apply('0, '0, '0, 1'b0);
        sent = '{default: 0}; clear_log(); cyc = 0;
        stall_left = 0; stalled = 1'b0; stall_checked = 1'b0; wc0 = 0;
        do begin
            @(negedge clk); cyc++;
            if (!stalled && blkpos == 10) begin stalled = 1'b1; stall_left = 5; wc0 = wcount; end
            if (stalled && !stall_checked && stall_left == 0) begin
                check("t3_stall_words", 32'(wcount - wc0), 32'd0);
                stall_checked = 1'b1;
            end
            w = '0; d = '0;
            for (int f = 0; f < FLUX; f++)
                if (sent[f] < 46 && !bus.in_full[f]) begin
                    w[f] = 1'b1; d[f*DATA_W +: DATA_W] = DATA_W'($urandom); sent[f]++;
                end
            apply(w, d, '0, stall_left > 0);
            if (stall_left > 0) stall_left--;
        end while ((sent[0] < 46 || sent[1] < 46 || mq[0].size() > 0 || mq[1].size() > 0) && cyc < 1000);
        check("t3_timeout", 32'(cyc < 1000), 32'd1);
        check("t3_stalled", 32'(stall_checked), 32'd1);
        check("t3_blocks", 32'(log_tag.size()), 32'd4);
        for (int i = 0; i < log_len.size(); i++) check("t3_len", 32'(log_len[i]), 32'd23);

        // 4: overfill flow 0 while downstream is full
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            if (j == 16) check("t4_full_after16", 32'(bus.in_full[0]), 32'd1);
            apply(2'b01, {8'h00, DATA_W'($urandom)}, '0, 1'b1);
        end
        @(negedge clk); apply('0, '0, '0, 1'b1);
        check("t4_ovf", 32'(bus.in_ovf[0]), 32'd1);
        w0 = words[0]; cyc = 0;
        do begin @(negedge clk); cyc++; apply('0, '0, '0, 1'b0); end
        while (mq[0].size() > 0 && cyc < 200);
        @(negedge clk);
        check("t4_drained", 32'(words[0] - w0), 32'd16);
        check("t4_full_clear", 32'(bus.in_full[0]), 32'd0);

        // 5: early block end on a last marker
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); apply(2'b01, {8'h00, DATA_W'(8'h50 + j)}, {1'b0, (j == 4 || j == 7)}, 1'b1);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); apply(2'b10, {DATA_W'($urandom), 8'h00}, {(j == 7), 1'b0}, 1'b1);
        end
        @(negedge clk); clear_log(); apply('0, '0, '0, 1'b0); cyc = 0;
        while (log_tag.size() < 3 && cyc < 200) begin @(negedge clk); cyc++; end
        check("t5_timeout", 32'(cyc < 200), 32'd1);
        if (log_tag.size() >= 3) begin
            check("t5_len0", 32'(log_len[0]), 32'd5);
            check("t5_tag0", 32'(log_tag[0]), 32'd0);
            check("t5_last0", 32'(log_last[0]), 32'd1);
            check("t5_tag1", 32'(log_tag[1]), 32'd1);
            check("t5_len1", 32'(log_len[1]), 32'd8);
            check("t5_len2", 32'(log_len[2]), 32'd3);
        end

        // 6: reset mid-burst, then refill
        @(negedge clk); bus.cfg_blk_len = LEN_W'(23);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); apply(2'b11, 16'($urandom), '0, 1'b1);
        end
        repeat (3) begin @(negedge clk); apply('0, '0, '0, 1'b0); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("t6_out_write", 32'(bus.out_write), 32'd0);
        check("t6_in_full", 32'(bus.in_full), 32'd0);
        check("t6_cur_flow", 32'(bus.cur_flow), 32'd0);
        bus.cfg_blk_len = LEN_W'(3); clear_log();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); apply(2'b11, 16'($urandom), '0, 1'b0);
        end
        @(negedge clk); apply('0, '0, '0, 1'b0); cyc = 0;
        while (log_tag.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
        check("t6_timeout", 32'(cyc < 100), 32'd1);
        if (log_tag.size() >= 2) begin
            check("t6_first_tag", 32'(log_tag[0]), 32'd0);
            check("t6_second_tag", 32'(log_tag[1]), 32'd1);
        end

        // random traffic: writes (some while full), last markers, stalls, block lengths 0..5
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c % 50 == 0) bus.cfg_blk_len = LEN_W'($urandom_range(0, 5));
            for (int f = 0; f < FLUX; f++) begin
                w[f] = ($urandom_range(0, 1) == 1) && (!bus.in_full[f] || $urandom_range(0, 7) == 0);
                l[f] = ($urandom_range(0, 7) == 0);
            end
            apply(w, 16'($urandom), l, $urandom_range(0, 3) == 0);
        end
        repeat (100) begin @(negedge clk); apply('0, '0, '0, 1'b0); end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
